// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for the five-stage RV32I core. It also contains the
// load-use hazard detector and the control-hazard flush for branches and
// jumps that resolve in EX.
//
// Ports
//   clk, reset            pipeline clock and synchronous active-high reset
//   *_id                  decoded fields of the instruction currently in ID
//   JumpFlush_ex          taken branch or jump resolved in EX this cycle
//   *_ex                  registered copies of the *_id fields. A bubble
//                         clears every one of them to zero.
//   Stall                 combinational; PC and IF/ID hold while it is high
//   IFID_Flush            combinational; IF/ID loads a NOP while it is high
//   BubbleCount           saturating count of bubbles inserted since reset
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [31:0]      PC_id,
    input  logic [31:0]      Imm_id,
    input  logic [31:0]      rs1Data_id,
    input  logic [31:0]      rs2Data_id,
    input  logic [4:0]       rs1Addr_id,
    input  logic [4:0]       rs2Addr_id,
    input  logic [4:0]       rdAddr_id,
    input  logic [3:0]       ALUCode_id,
    input  logic             ALUSrcA_id,
    input  logic [1:0]       ALUSrcB_id,
    input  logic             RegWrite_id,
    input  logic             MemWrite_id,
    input  logic             MemRead_id,
    input  logic             MemtoReg_id,

    input  logic             JumpFlush_ex,

    output logic [31:0]      PC_ex,
    output logic [31:0]      Imm_ex,
    output logic [31:0]      rs1Data_ex,
    output logic [31:0]      rs2Data_ex,
    output logic [4:0]       rs1Addr_ex,
    output logic [4:0]       rs2Addr_ex,
    output logic [4:0]       rdAddr_ex,
    output logic [3:0]       ALUCode_ex,
    output logic             ALUSrcA_ex,
    output logic [1:0]       ALUSrcB_ex,
    output logic             RegWrite_ex,
    output logic             MemWrite_ex,
    output logic             MemRead_ex,
    output logic             MemtoReg_ex,

    output logic             Stall,
    output logic             IFID_Flush,
    output logic [CNT_W-1:0] BubbleCount
);

    logic             load_use;
    logic             bubble;
    logic [CNT_W-1:0] bubble_count_reg;
    logic [CNT_W-1:0] bubble_count_next;

    // A load in EX whose destination is read by the instruction in ID. Both
    // source fields are compared even if the instruction does not use them;
    // the occasional false stall is accepted. x0 is excluded through rd only.
    assign load_use = MemRead_ex & RegWrite_ex & (rdAddr_ex != 5'd0) &
                      ((rdAddr_ex == rs1Addr_id) | (rdAddr_ex == rs2Addr_id));

    // A flush discards the younger instruction in ID, so no stall is needed.
    assign Stall      = load_use & ~JumpFlush_ex;
    assign IFID_Flush = JumpFlush_ex;

    // Flush and load-use both insert exactly one bubble. When they occur in
    // the same cycle, only one bubble is inserted and only one is counted.
    assign bubble = JumpFlush_ex | load_use;

    always_comb begin
        bubble_count_next = bubble_count_reg;
        if (bubble && (bubble_count_reg != {CNT_W{1'b1}})) begin
            bubble_count_next = bubble_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_count_reg <= '0;
        end else begin
            bubble_count_reg <= bubble_count_next;
        end
    end

    assign BubbleCount = bubble_count_reg;

    // A bubble zeroes every field, including data, addresses and PC. The
    // result is a true NOP: no writes, and rdAddr_ex = 0 so it never matches
    // in the forwarding unit. It also clears MemRead_ex, which guarantees
    // that a load-use stall lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            PC_ex       <= 32'd0;
            Imm_ex      <= 32'd0;
            rs1Data_ex  <= 32'd0;
            rs2Data_ex  <= 32'd0;
            rs1Addr_ex  <= 5'd0;
            rs2Addr_ex  <= 5'd0;
            rdAddr_ex   <= 5'd0;
            ALUCode_ex  <= 4'd0;
            ALUSrcA_ex  <= 1'b0;
            ALUSrcB_ex  <= 2'd0;
            RegWrite_ex <= 1'b0;
            MemWrite_ex <= 1'b0;
            MemRead_ex  <= 1'b0;
            MemtoReg_ex <= 1'b0;
        end else begin
            PC_ex       <= PC_id;
            Imm_ex      <= Imm_id;
            rs1Data_ex  <= rs1Data_id;
            rs2Data_ex  <= rs2Data_id;
            rs1Addr_ex  <= rs1Addr_id;
            rs2Addr_ex  <= rs2Addr_id;
            rdAddr_ex   <= rdAddr_id;
            ALUCode_ex  <= ALUCode_id;
            ALUSrcA_ex  <= ALUSrcA_id;
            ALUSrcB_ex  <= ALUSrcB_id;
            RegWrite_ex <= RegWrite_id;
            MemWrite_ex <= MemWrite_id;
            MemRead_ex  <= MemRead_id;
            MemtoReg_ex <= MemtoReg_id;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed bench for id_ex_stage, built with CNT_W = 4 so that counter
// saturation can be reached. The scenarios are reset, pass-through,
// load-use on rs1 and rs2, no-false-stall cases, flush versus stall,
// saturation, and reset in mid-operation.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      PC_id, Imm_id, rs1Data_id, rs2Data_id;
    logic [4:0]       rs1Addr_id, rs2Addr_id, rdAddr_id;
    logic [3:0]       ALUCode_id;
    logic             ALUSrcA_id;
    logic [1:0]       ALUSrcB_id;
    logic             RegWrite_id, MemWrite_id, MemRead_id, MemtoReg_id;
    logic             JumpFlush_ex;
    logic [31:0]      PC_ex, Imm_ex, rs1Data_ex, rs2Data_ex;
    logic [4:0]       rs1Addr_ex, rs2Addr_ex, rdAddr_ex;
    logic [3:0]       ALUCode_ex;
    logic             ALUSrcA_ex;
    logic [1:0]       ALUSrcB_ex;
    logic             RegWrite_ex, MemWrite_ex, MemRead_ex, MemtoReg_ex;
    logic             Stall, IFID_Flush;
    logic [CNT_W-1:0] BubbleCount;

    int checks = 0;
    int errors = 0;
    int cnt_exp = 0;

    logic [153:0] ex_bus;
    assign ex_bus = {PC_ex, Imm_ex, rs1Data_ex, rs2Data_ex,
                     rs1Addr_ex, rs2Addr_ex, rdAddr_ex, ALUCode_ex,
                     ALUSrcA_ex, ALUSrcB_ex,
                     RegWrite_ex, MemWrite_ex, MemRead_ex, MemtoReg_ex};

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .PC_id(PC_id), .Imm_id(Imm_id),
        .rs1Data_id(rs1Data_id), .rs2Data_id(rs2Data_id),
        .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id), .rdAddr_id(rdAddr_id),
        .ALUCode_id(ALUCode_id), .ALUSrcA_id(ALUSrcA_id), .ALUSrcB_id(ALUSrcB_id),
        .RegWrite_id(RegWrite_id), .MemWrite_id(MemWrite_id),
        .MemRead_id(MemRead_id), .MemtoReg_id(MemtoReg_id),
        .JumpFlush_ex(JumpFlush_ex),
        .PC_ex(PC_ex), .Imm_ex(Imm_ex),
        .rs1Data_ex(rs1Data_ex), .rs2Data_ex(rs2Data_ex),
        .rs1Addr_ex(rs1Addr_ex), .rs2Addr_ex(rs2Addr_ex), .rdAddr_ex(rdAddr_ex),
        .ALUCode_ex(ALUCode_ex), .ALUSrcA_ex(ALUSrcA_ex), .ALUSrcB_ex(ALUSrcB_ex),
        .RegWrite_ex(RegWrite_ex), .MemWrite_ex(MemWrite_ex),
        .MemRead_ex(MemRead_ex), .MemtoReg_ex(MemtoReg_ex),
        .Stall(Stall), .IFID_Flush(IFID_Flush), .BubbleCount(BubbleCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] obs,
                         input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] rd, input logic [3:0] alu,
                          input logic srca, input logic [1:0] srcb,
                          input logic rw, input logic mw,
                          input logic mr, input logic m2r);
        PC_id = pc; Imm_id = imm; rs1Data_id = d1; rs2Data_id = d2;
        rs1Addr_id = a1; rs2Addr_id = a2; rdAddr_id = rd; ALUCode_id = alu;
        ALUSrcA_id = srca; ALUSrcB_id = srcb;
        RegWrite_id = rw; MemWrite_id = mw; MemRead_id = mr; MemtoReg_id = m2r;
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two cycles with random inputs.
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_id($urandom, $urandom, $urandom, $urandom,
                   5'($urandom), 5'($urandom), 5'($urandom), 4'($urandom),
                   1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
            JumpFlush_ex = 1'($urandom);
            step();
            check("reset_ex", 160'(ex_bus), 160'd0);
            check("reset_cnt", 160'(BubbleCount), 160'd0);
        end

        // First edge after reset passes PC_id through.
        reset = 1'b0;
        JumpFlush_ex = 1'b0;
        set_id(32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("first_pc", 160'(PC_ex), 160'h10);

        // Pass-through: add x3,x1,x2.
        set_id(32'h14, 0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 4'd0, 0, 2'd0, 1, 0, 0, 0);
        step();
        check("pass_ex", 160'(ex_bus),
              160'({32'h14, 32'h0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 4'd0,
                    1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
        check("pass_stall", 160'(Stall), 160'd0);

        // lw x5,8(x1) enters EX.
        set_id(32'h18, 32'd8, 32'd100, 0, 5'd1, 5'd0, 5'd5, 4'd0, 0, 2'd1, 1, 0, 1, 1);
        step();
        check("lw_in_ex", 160'({MemRead_ex, RegWrite_ex, rdAddr_ex}), 160'({1'b1, 1'b1, 5'd5}));
        // add x6,x1,x5 in ID: hazard on rs2.
        set_id(32'h1c, 0, 32'd5, 32'd0, 5'd1, 5'd5, 5'd6, 4'd0, 0, 2'd0, 1, 0, 0, 0);
        #1;
        check("lu_stall", 160'(Stall), 160'd1);
        check("lu_noflush", 160'(IFID_Flush), 160'd0);
        step();
        cnt_exp = 1;
        check("lu_bubble", 160'(ex_bus), 160'd0);
        check("lu_cnt", 160'(BubbleCount), 160'(cnt_exp));
        check("lu_stall_once", 160'(Stall), 160'd0);
        step();
        check("lu_add_rd", 160'(rdAddr_ex), 160'd6);
        check("lu_add_pc", 160'(PC_ex), 160'h1c);
        check("lu_cnt_hold", 160'(BubbleCount), 160'(cnt_exp));

        // lw x0 enters EX; instruction reading x0 must not stall.
        set_id(32'h20, 32'd4, 0, 0, 5'd2, 5'd0, 5'd0, 4'd0, 0, 2'd1, 1, 0, 1, 1);
        step();
        set_id(32'h24, 32'd12, 0, 0, 5'd0, 5'd0, 5'd5, 4'd0, 0, 2'd1, 1, 0, 1, 1);
        #1;
        check("x0_nostall", 160'(Stall), 160'd0);
        // That lw x5 (rs1=x0) loads into EX.
        step();
        check("lw5_in_ex", 160'({MemRead_ex, rdAddr_ex, PC_ex}), 160'({1'b1, 5'd5, 32'h24}));
        set_id(32'h28, 0, 0, 0, 5'd4, 5'd6, 5'd7, 4'd0, 0, 2'd0, 1, 0, 0, 0);
        #1;
        check("nofalse_stall", 160'(Stall), 160'd0);
        rs1Addr_id = 5'd5;
        #1;
        check("rs1_stall", 160'(Stall), 160'd1);

        // Flush in the same cycle as the load-use hazard.
        JumpFlush_ex = 1'b1;
        #1;
        check("fl_stall", 160'(Stall), 160'd0);
        check("fl_ifid", 160'(IFID_Flush), 160'd1);
        step();
        cnt_exp = cnt_exp + 1;
        check("fl_bubble", 160'(ex_bus), 160'd0);
        check("fl_cnt", 160'(BubbleCount), 160'(cnt_exp));

        // Saturation: 20 consecutive flushes with a live instruction in ID.
        set_id(32'h30, 32'h55, 32'h66, 32'h77, 5'd3, 5'd4, 5'd9, 4'd2, 1, 2'd2, 1, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step();
            cnt_exp = (cnt_exp < 15) ? cnt_exp + 1 : 15;
            check("sat_cnt", 160'(BubbleCount), 160'(cnt_exp));
        end
        check("sat_bubble", 160'(ex_bus), 160'd0);

        // No bubble: the counter holds at 15 and the instruction passes through.
        JumpFlush_ex = 1'b0;
        set_id(32'h34, 32'd0, 32'd1, 32'd2, 5'd1, 5'd2, 5'd9, 4'd0, 0, 2'd1, 1, 0, 1, 1);
        step();
        check("sat_hold", 160'(BubbleCount), 160'd15);
        check("post_sat_rd", 160'(rdAddr_ex), 160'd9);

        // Reset in mid-operation, with a hazard and a flush both pending.
        reset = 1'b1;
        JumpFlush_ex = 1'b1;
        rs1Addr_id = 5'd9;
        step();
        check("midreset_ex", 160'(ex_bus), 160'd0);
        check("midreset_cnt", 160'(BubbleCount), 160'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the five-stage RV32I core. Registers every decoded field from the ID stage into the EX stage and contains the load-use hazard detector. Also implements the control-hazard flush for branches and jumps resolved in EX. Its outputs directly drive the EX-stage operand muxes, forwarding unit and ALU, and the MEM/WB control path.

## Interface
Parameters:
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- PC_id  in  32  PC of instruction in ID.
- Imm_id  in  32  sign-extended immediate.
- rs1Data_id, rs2Data_id  in  32  register-file read data.
- rs1Addr_id, rs2Addr_id, rdAddr_id  in  5  register addresses.
- ALUCode_id  in  4  ALU operation.
- ALUSrcA_id  in  1  0 = rs1, 1 = PC.
- ALUSrcB_id  in  2  0 = rs2, 1 = Imm, 2 = constant 4.
- RegWrite_id, MemWrite_id, MemRead_id, MemtoReg_id  in  1  control bits.
- JumpFlush_ex  in  1  taken branch or jump resolved in EX this cycle.
- PC_ex, Imm_ex, rs1Data_ex, rs2Data_ex  out  32  registered copies.
- rs1Addr_ex, rs2Addr_ex, rdAddr_ex  out  5  registered copies.
- ALUCode_ex  out  4; ALUSrcA_ex  out  1; ALUSrcB_ex  out  2  registered copies.
- RegWrite_ex, MemWrite_ex, MemRead_ex, MemtoReg_ex  out  1  registered copies.
- Stall  out  1  combinational; when high, the PC and IF/ID registers hold.
- IFID_Flush  out  1  combinational; when high, IF/ID loads a NOP.
- BubbleCount  out  CNT_W  number of bubbles inserted since reset, saturating.

## Operation
- Hazard detection (combinational): LoadUse = MemRead_ex & RegWrite_ex & (rdAddr_ex != 0) & ((rdAddr_ex == rs1Addr_id) | (rdAddr_ex == rs2Addr_id)).
- Stall = LoadUse & ~JumpFlush_ex.
- IFID_Flush = JumpFlush_ex.
- Register update at each rising edge, in priority order:
  - reset: every _ex output is 0 and BubbleCount is 0.
  - JumpFlush_ex: insert a bubble.
  - LoadUse: insert a bubble.
  - otherwise: load every _id input into its _ex register.
- A bubble sets every _ex output to 0, including data, address and PC fields. It is a NOP: no register or memory write, and it causes no forwarding match because rdAddr_ex = 0.
- Flush takes priority over a load-use stall in the same cycle. The younger instruction in ID is discarded, so no stall is required.
- BubbleCount increments by 1 on every inserted bubble. It holds at 2^CNT_W − 1 and never wraps. Reset bubbles are not counted.
- The stage has no internal FSM beyond these registers. A stall lasts exactly one cycle, because the next state has MemRead_ex = 0, which breaks the hazard condition.
- rs1 and rs2 are compared regardless of whether the instruction uses them. False stalls on unused fields are accepted. Address x0 is handled only through the rdAddr_ex != 0 term.

## Timing
- Latency: one cycle from the ID inputs to the _ex outputs.
- Stall and IFID_Flush are valid in the same cycle as the inputs that cause them. They must settle before the clock edge and contain no registered delay.
- Load-use sequence:
  - cycle t: lw in EX, dependent instruction in ID; Stall = 1.
  - cycle t+1: bubble in EX, dependent instruction still in ID; Stall = 0.
  - cycle t+2: dependent instruction in EX; its operand comes from the WB forwarding path.
- Flush: JumpFlush_ex is high in cycle t. In t+1 EX holds a bubble and ID holds a NOP, which gives a two-instruction penalty.
- Reset mid-operation: all registers clear at the next edge whether or not a stall or flush is pending. Stall can still assert combinationally during reset; upstream reset dominates it.
- Back-to-back loads where each depends on the previous: each pair stalls exactly one cycle.

## Test plan
- Reset: with reset = 1 for 2 cycles and random inputs, every _ex output is 0 and BubbleCount = 0. After deassertion, the first edge passes PC_id = 0x00000010 through to PC_ex.
- Pass-through: apply add x3,x1,x2 fields (ALUCode_id = 0, RegWrite_id = 1, rdAddr_id = 3, rs1Data_id = 5, rs2Data_id = 7). One cycle later all of these appear identically on the _ex outputs, and Stall = 0.
- Load-use on rs2: lw x5 in EX (MemRead_ex = 1, rdAddr_ex = 5), then add x6,x1,x5 in ID.
  - Stall = 1 for exactly one cycle.
  - Next cycle: RegWrite_ex = 0, rdAddr_ex = 0, BubbleCount = 1.
  - The cycle after: the add is in EX with rdAddr_ex = 6.
- No false stall: lw x0 in EX with rs1Addr_id = 0 gives Stall = 0. lw x5 with rs1Addr_id = 4 and rs2Addr_id = 6 gives Stall = 0.
- Flush versus stall: assert JumpFlush_ex in the same cycle as a load-use hazard.
  - Stall = 0 and IFID_Flush = 1.
  - Next cycle: the _ex outputs hold a bubble and BubbleCount increments by 1, not 2.
- Saturation: with CNT_W = 4, force 20 consecutive flushes. BubbleCount reaches 15 and holds at 15.
